// File: rtl/alu_mc_if.sv
// alu_mc request/result bundle with valid/ready on both sides.
// Decode side drives master, the ALU owns slave.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             div_by_zero;
  logic             illegal;

  modport master (
    output in_valid, a, b, alu_ctrl, out_ready,
    input  in_ready, out_valid, res, res_hi,
    input  zero, carry_out, overflow,
    input  div_by_zero, illegal
  );

  modport slave (
    input  in_valid, a, b, alu_ctrl, out_ready,
    output in_ready, out_valid, res, res_hi,
    output zero, carry_out, overflow,
    output div_by_zero, illegal
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle MIPS ALU: 1-cycle ALU ops, iterative MULTU/DIVU.
// Define ALU_MC_SIGNED_MULDIV_EN to add signed MULT/DIV.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic    clk,
  input logic    rst_n,
  alu_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a, b;
  assign a = bus.a;
  assign b = bus.b;

  logic c_and, c_or, c_add, c_sub, c_slt, c_nor;
  logic c_mulu, c_divu, c_muls, c_divs, c_ill;
  assign c_and  = bus.alu_ctrl == 4'b0000;
  assign c_or   = bus.alu_ctrl == 4'b0001;
  assign c_add  = bus.alu_ctrl == 4'b0010;
  assign c_sub  = bus.alu_ctrl == 4'b0110;
  assign c_slt  = bus.alu_ctrl == 4'b0111;
  assign c_nor  = bus.alu_ctrl == 4'b1100;
  assign c_mulu = bus.alu_ctrl == 4'b1000;
  assign c_divu = bus.alu_ctrl == 4'b1001;
`ifdef ALU_MC_SIGNED_MULDIV_EN
  assign c_muls = bus.alu_ctrl == 4'b1010;
  assign c_divs = bus.alu_ctrl == 4'b1011;
`else
  assign c_muls = 1'b0;
  assign c_divs = 1'b0;
`endif
  assign c_ill = !(c_and | c_or | c_add | c_sub | c_slt
                 | c_nor | c_mulu | c_divu | c_muls | c_divs);

  logic is_mul, is_div, dz, iter, accept;
  assign is_mul = c_mulu | c_muls;
  assign is_div = c_divu | c_divs;
  assign dz     = is_div && (b == '0);
  assign iter   = (is_mul | is_div) && !dz;

  assign bus.in_ready = rst_n &&
    (state == IDLE || (state == DONE && bus.out_ready));
  assign accept    = bus.in_valid && bus.in_ready;
  assign bus.out_valid = state == DONE;

  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (1'b1)
      c_and: alu_res = a & b;
      c_or:  alu_res = a | b;
      c_nor: alu_res = ~(a | b);
      c_add: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);
      end
      c_sub: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (dif[WIDTH-1] != a[WIDTH-1]);
      end
      c_slt: alu_res = {{(WIDTH-1){1'b0}},
                        $signed(a) < $signed(b)};
      default: ;
    endcase
  end

  // Signed ops run on magnitudes; signs are reapplied at the end
  logic             sa, sb, ovf_in;
  logic [WIDTH-1:0] ma, mb;
  assign sa = (c_muls | c_divs) & a[WIDTH-1];
  assign sb = (c_muls | c_divs) & b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign ovf_in = c_divs && b == '1 &&
                  a == {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] hi, lo, m;
  logic [CNT_W-1:0] cnt;
  logic             div_r, neg_lo, neg_hi, ovf_r;

  logic [WIDTH:0]   sum_m, sh;
  logic [WIDTH-1:0] df, hi_n, lo_n;
  logic             ge;

  always_comb begin
    sum_m = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sh    = {hi, lo[WIDTH-1]};
    ge    = sh >= {1'b0, m};
    df    = sh[WIDTH-1:0] - m;
    if (div_r) begin
      hi_n = ge ? df : sh[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end else begin
      hi_n = sum_m[WIDTH:1];
      lo_n = {sum_m[0], lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   fin_lo, fin_hi;
  assign prod   = {hi_n, lo_n};
  assign prod_s = neg_lo ? -prod : prod;
  assign fin_lo = div_r ? (neg_lo ? -lo_n : lo_n)
                        : prod_s[WIDTH-1:0];
  assign fin_hi = div_r ? (neg_hi ? -hi_n : hi_n)
                        : prod_s[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = iter ? BUSY : DONE;
      BUSY: if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE: begin
        if (accept)             state_nx = iter ? BUSY : DONE;
        else if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  logic [WIDTH-1:0] res_r, res_hi_r;
  logic             zero_r, c_r, v_r, dz_r, ill_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0; lo <= '0; m <= '0; cnt <= '0;
      div_r <= 1'b0; neg_lo <= 1'b0;
      neg_hi <= 1'b0; ovf_r <= 1'b0;
      res_r <= '0; res_hi_r <= '0; zero_r <= 1'b0;
      c_r <= 1'b0; v_r <= 1'b0;
      dz_r <= 1'b0; ill_r <= 1'b0;
    end else if (accept) begin
      if (iter) begin
        hi     <= '0;
        lo     <= is_mul ? mb : ma;
        m      <= is_mul ? ma : mb;
        cnt    <= CNT_W'(WIDTH);
        div_r  <= is_div;
        neg_lo <= sa ^ sb;
        neg_hi <= is_div ? sa : (sa ^ sb);
        ovf_r  <= ovf_in;
      end else if (dz) begin
        res_r <= '1; res_hi_r <= a; zero_r <= 1'b0;
        c_r <= 1'b0; v_r <= 1'b0;
        dz_r <= 1'b1; ill_r <= 1'b0;
      end else begin
        res_r    <= alu_res;
        res_hi_r <= '0;
        zero_r   <= alu_res == '0;
        c_r      <= alu_c;
        v_r      <= alu_v;
        dz_r     <= 1'b0;
        ill_r    <= c_ill;
      end
    end else if (state == BUSY) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        res_r <= fin_lo; res_hi_r <= fin_hi;
        zero_r <= fin_lo == '0;
        c_r <= 1'b0; v_r <= ovf_r;
        dz_r <= 1'b0; ill_r <= 1'b0;
      end
    end
  end

  assign bus.res         = res_r;
  assign bus.res_hi      = res_hi_r;
  assign bus.zero        = zero_r;
  assign bus.carry_out   = c_r;
  assign bus.overflow    = v_r;
  assign bus.div_by_zero = dz_r;
  assign bus.illegal     = ill_r;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc with WIDTH=32.
// Expected values are hand-computed constants.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;
  int   lat;
  logic stable_ok;
  logic [31:0] hold_res;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; lat = edges from request up to out_valid
  task automatic run_op(input logic [3:0] ctrl,
                        input logic [31:0] av,
                        input logic [31:0] bv,
                        output int l);
    bus.alu_ctrl = ctrl;
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    l = 1;
    while (!bus.out_valid && l < 100) begin
      step();
      l++;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alu_ctrl  = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 0);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_res", 64'(bus.res), 0);
    check("rst_zero", 64'(bus.zero), 0);
    step();
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 64'(bus.in_ready), 1);

    // back-to-back ALU ops
    bus.alu_ctrl = 4'b0010;
    bus.a = 32'h7FFF_FFFF;
    bus.b = 32'h1;
    bus.in_valid = 1'b1;
    step();
    check("add_valid", 64'(bus.out_valid), 1);
    check("add_res", 64'(bus.res), 64'h8000_0000);
    check("add_ovf", 64'(bus.overflow), 1);
    check("add_carry", 64'(bus.carry_out), 0);
    bus.alu_ctrl = 4'b0110;
    bus.a = 32'h0;
    bus.b = 32'h0;
    step();
    check("sub_res", 64'(bus.res), 0);
    check("sub_zero", 64'(bus.zero), 1);
    check("sub_carry", 64'(bus.carry_out), 1);
    check("sub_ovf", 64'(bus.overflow), 0);
    bus.alu_ctrl = 4'b0111;
    bus.a = -32'sd14;
    bus.b = -32'sd12;
    step();
    check("slt_res", 64'(bus.res), 1);
    check("slt_zero", 64'(bus.zero), 0);
    bus.in_valid = 1'b0;
    step();
    check("done_to_idle", 64'(bus.out_valid), 0);

    // MULTU boundary, in_ready low while busy
    bus.alu_ctrl = 4'b1000;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    stable_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) stable_ok = 1'b0;
      step();
      lat++;
    end
    check("mulu_lat", 64'(lat), 33);
    check("mulu_busy_rdy", 64'(stable_ok), 1);
    check("mulu_hi", 64'(bus.res_hi), 64'hFFFF_FFFE);
    check("mulu_lo", 64'(bus.res), 64'h1);
    step();

    run_op(4'b1000, 32'd1234, 32'd5678, lat);
    check("mulu2_lo", 64'(bus.res), 64'd7006652);
    check("mulu2_hi", 64'(bus.res_hi), 0);
    step();

    run_op(4'b1001, 32'd100, 32'd7, lat);
    check("divu_lat", 64'(lat), 33);
    check("divu_q", 64'(bus.res), 14);
    check("divu_r", 64'(bus.res_hi), 2);
    check("divu_dz", 64'(bus.div_by_zero), 0);
    step();

    run_op(4'b1001, 32'd3, 32'd10, lat);
    check("divu_small_q", 64'(bus.res), 0);
    check("divu_small_r", 64'(bus.res_hi), 3);
    check("divu_small_z", 64'(bus.zero), 1);
    step();

    run_op(4'b1001, 32'd5, 32'd0, lat);
    check("dz_lat", 64'(lat), 1);
    check("dz_res", 64'(bus.res), 64'hFFFF_FFFF);
    check("dz_hi", 64'(bus.res_hi), 5);
    check("dz_flag", 64'(bus.div_by_zero), 1);
    step();

    // backpressure holds AND result
    bus.out_ready = 1'b0;
    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    check("and_lat", 64'(lat), 1);
    check("and_res", 64'(bus.res), 64'hF000_F000);
    hold_res = bus.res;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.res !== hold_res || !bus.out_valid ||
          bus.in_ready || bus.zero || bus.illegal)
        stable_ok = 1'b0;
    end
    check("bp_stable", 64'(stable_ok), 1);
    check("bp_res", 64'(bus.res), 64'hF000_F000);
    bus.out_ready = 1'b1;
    bus.alu_ctrl = 4'b1100;
    bus.a = 32'h0;
    bus.b = 32'h0000_FFFF;
    bus.in_valid = 1'b1;
    #1;
    check("bp_release_rdy", 64'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    check("nor_res", 64'(bus.res), 64'hFFFF_0000);
    check("nor_valid", 64'(bus.out_valid), 1);
    step();

    // reset in the middle of MULTU
    bus.alu_ctrl = 4'b1000;
    bus.a = 32'h1234_5678;
    bus.b = 32'h9ABC_DEF0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 64'(bus.out_valid), 0);
    check("mrst_rdy", 64'(bus.in_ready), 0);
    check("mrst_res", 64'(bus.res), 0);
    check("mrst_hi", 64'(bus.res_hi), 0);
    step();
    rst_n = 1'b1;
    #1;
    check("mrst_idle_rdy", 64'(bus.in_ready), 1);
    run_op(4'b0001, 32'hF0, 32'h0F, lat);
    check("or_lat", 64'(lat), 1);
    check("or_res", 64'(bus.res), 64'hFF);
    step();

    run_op(4'b1101, 32'h55, 32'h33, lat);
    check("ill_flag", 64'(bus.illegal), 1);
    check("ill_res", 64'(bus.res), 0);
    check("ill_zero", 64'(bus.zero), 1);
    step();

`ifdef ALU_MC_SIGNED_MULDIV_EN
    run_op(4'b1011, -32'sd7, 32'sd2, lat);
    check("div_lat", 64'(lat), 33);
    check("div_q", 64'(bus.res), 64'hFFFF_FFFD);
    check("div_r", 64'(bus.res_hi), 64'hFFFF_FFFF);
    step();
    run_op(4'b1010, -32'sd3, 32'sd5, lat);
    check("mul_lo", 64'(bus.res), 64'hFFFF_FFF1);
    check("mul_hi", 64'(bus.res_hi), 64'hFFFF_FFFF);
    step();
    run_op(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("divovf_q", 64'(bus.res), 64'h8000_0000);
    check("divovf_r", 64'(bus.res_hi), 0);
    check("divovf_v", 64'(bus.overflow), 1);
    step();
`else
    run_op(4'b1010, 32'd3, 32'd5, lat);
    check("mult_ill", 64'(bus.illegal), 1);
    check("mult_ill_lat", 64'(lat), 1);
    step();
    run_op(4'b1011, 32'd9, 32'd2, lat);
    check("div_ill", 64'(bus.illegal), 1);
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the combinational MIPS ALU.
- Executes the single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) with a one-cycle registered latency.
- Adds iterative unsigned multiply and divide producing HI/LO results.
- Sits between the decode stage and writeback behind a valid/ready handshake; holds its result until it is consumed.

Parameters:
- WIDTH, 32, operand and result width; legal range 4 to 64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_ctrl  input  4  operation select.
- out_valid  output  1  result registers valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- res  output  WIDTH  result (LO for mul/div).
- res_hi  output  WIDTH  HI result: product high half or remainder; 0 for ALU ops.
- zero  output  1  res == 0.
- carry_out  output  1  carry from ADD, or NOT borrow from SUB; 0 otherwise.
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
- div_by_zero  output  1  DIV was issued with b == 0.
- illegal  output  1  unsupported alu_ctrl code.

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
  - 1000 MULTU, 1001 DIVU.
  - 1010 MULT and 1011 DIV only with the optional feature.
  - All other codes: illegal.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including in_ready, which is forced 0 while rst_n is low.
  - An operation in flight is discarded.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating mul/div.
  - DONE: out_valid=1.
- Handshake:
  - Accept occurs when in_valid && in_ready. Operands and op are captured at that edge; later input changes are ignored.
  - in_ready = IDLE || (DONE && out_ready), so ALU ops run back-to-back at one per cycle.
  - All result outputs are stable while out_valid=1 && out_ready=0.
- ALU ops and illegal codes:
  - Accept goes directly to DONE; result is visible on the next edge (latency 1).
  - Illegal codes give res=0, res_hi=0, zero=1, illegal=1.
- Arithmetic:
  - ADD/SUB are computed at WIDTH+1 bits.
  - overflow = operand signs agree (with b inverted for SUB) and the result sign differs.
  - SLT uses the true signed comparison, which stays correct on subtract overflow; res = {0..0, lt}.
- MULTU:
  - Shift-add over WIDTH iterations; the counter counts WIDTH down to 1.
  - {res_hi, res} = a*b as a 2*WIDTH unsigned product.
  - out_valid rises WIDTH+1 edges after accept.
- DIVU:
  - Restoring division over WIDTH iterations; res = quotient, res_hi = remainder; same latency as MULTU.
- Divide by zero:
  - Takes no iterations; goes to DONE after 1 cycle.
  - res = all ones, res_hi = a, div_by_zero=1.
- zero flag: reflects res only, for all ops.
- Leaving DONE:
  - DONE with out_ready=1 and no new accept goes to IDLE and clears out_valid.
  - A simultaneous new accept loads the new op instead.
- Boundaries:
  - MULTU of all-ones by all-ones gives res_hi = all-ones minus 1, res = 1.
  - DIVU with a < b gives res = 0, res_hi = a.

Optional Feature:
- Macro: ALU_MC_SIGNED_MULDIV_EN.
- Defined:
  - Codes 1010 (MULT) and 1011 (DIV) are supported.
  - Operands are converted to magnitudes and the unsigned engine is reused.
  - Signs are fixed at the end: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Latency is identical to the unsigned ops.
  - Most-negative / -1 yields res = most-negative, res_hi = 0, overflow=1.
- Undefined: 1010 and 1011 are illegal codes.

Test Plan:
- Sequence with WIDTH=32 and out_ready=1:
  - ADD 0x7FFFFFFF+1 -> next cycle res=0x80000000, overflow=1, carry_out=0.
  - Then SUB 0-0 -> res=0, zero=1.
  - Then SLT -14,-12 -> res=1.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid exactly 33 edges after accept; res_hi=0xFFFFFFFE, res=0x00000001. in_ready=0 throughout BUSY.
- DIVU a=100, b=7 -> res=14, res_hi=2. DIVU a=5, b=0 -> res=0xFFFFFFFF, res_hi=5, div_by_zero=1, out_valid one edge after accept.
- Backpressure: AND result held for 5 cycles with out_ready=0 -> res, flags and out_valid stable; in_ready=0. Raise out_ready together with a new in_valid -> new result on the following edge.
- Reset mid-MULTU: rst_n low at iteration 10 -> outputs 0 immediately. After release, in_ready=1; a new OR 0xF0|0x0F gives res=0xFF.
- alu_ctrl=1101 -> illegal=1, res=0, zero=1. With ALU_MC_SIGNED_MULDIV_EN: DIV -7/2 -> res=-3, res_hi=-1.
